// File: rtl/alu_pkg.sv
// Shared encodings for the multi-cycle ALU: operation codes, status bit
// positions, controller states and iterative-unit modes.
package alu_pkg;

  typedef enum logic [3:0] {
    OP_ADD  = 4'd0,
    OP_SUB  = 4'd1,
    OP_AND  = 4'd2,
    OP_OR   = 4'd3,
    OP_XOR  = 4'd4,
    OP_NOT  = 4'd5,
    OP_SHL  = 4'd6,
    OP_SHR  = 4'd7,
    OP_SAR  = 4'd8,
    OP_LOAD = 4'd9,
    OP_CMP  = 4'd10,
    OP_MUL  = 4'd11,
    OP_DIVU = 4'd12,
    OP_REMU = 4'd13
  } op_e;

  localparam int STATUS_W = 7;
  localparam int SB_Z  = 0;
  localparam int SB_C  = 1;
  localparam int SB_N  = 2;
  localparam int SB_EQ = 3;
  localparam int SB_GT = 4;
  localparam int SB_LT = 5;
  localparam int SB_DZ = 6;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_MUL_RUN = 2'd1,
    ST_DIV_RUN = 2'd2
  } state_e;

  typedef enum logic [1:0] {
    IT_MUL  = 2'd0,
    IT_DIVU = 2'd1,
    IT_REMU = 2'd2
  } iter_mode_e;

  function automatic logic is_multi(input logic [3:0] op);
    return (op == OP_MUL) || (op == OP_DIVU) || (op == OP_REMU);
  endfunction

endpackage

// File: rtl/alu_mc_if.sv
// Issue/result bundle between the instruction decoder (master) and alu_mc (slave).
interface alu_mc_if #(
  parameter int WIDTH = 16,
  parameter int NREGS = 8
) ();
  localparam int IW = $clog2(NREGS);
  localparam int SW = $clog2(WIDTH);

  // An operation transfers on a rising edge where op_valid && op_ready; the
  // master holds its fields stable while op_valid is high and op_ready is low.
  logic                 op_valid;
  logic                 op_ready;
  logic [3:0]           op_code;
  logic [IW-1:0]        src1_idx;
  logic [IW-1:0]        src2_idx;
  logic [IW-1:0]        dst_idx;
  logic                 use_imm;
  logic [WIDTH-1:0]     imm;
  logic [SW-1:0]        shamt;
  logic [WIDTH-1:0]     dout;
  logic                 done;
  logic [6:0]           status;
  alu_pkg::state_e      dbg_state;

  modport master (
    output op_valid, op_code, src1_idx, src2_idx, dst_idx, use_imm, imm, shamt,
    input  op_ready, dout, done, status, dbg_state
  );

  modport slave (
    input  op_valid, op_code, src1_idx, src2_idx, dst_idx, use_imm, imm, shamt,
    output op_ready, dout, done, status, dbg_state
  );
endinterface

// File: rtl/alu_iter.sv
// Iterative datapath: shift-add multiply and restoring unsigned divide, one
// bit per cycle; the final step is presented combinationally on result.
module alu_iter import alu_pkg::*; #(
  parameter int WIDTH = 16
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             start,
  input  iter_mode_e       mode,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] result,
  output logic             hi_nz,
  output logic             dz,
  output logic             last
);
  localparam int CW = $clog2(WIDTH);

  logic             busy;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;
  logic [WIDTH-1:0] m;
  iter_mode_e       mode_q;

  logic [WIDTH:0]   sum;
  logic [WIDTH+1:0] shifted;
  logic [WIDTH+1:0] diff;
  logic [WIDTH-1:0] n_hi;
  logic [WIDTH-1:0] n_lo;

  // hi/lo are the product halves for multiply, remainder/quotient for divide.
  // Divide by zero needs no special case: every trial subtract succeeds, so the
  // quotient fills with ones and the dividend shifts whole into the remainder.
  always_comb begin
    sum     = {1'b0, hi} + (lo[0] ? {1'b0, m} : '0);
    shifted = {1'b0, hi, lo[WIDTH-1]};
    diff    = shifted - {2'b00, m};
    if (mode_q == IT_MUL) begin
      n_hi = sum[WIDTH:1];
      n_lo = {sum[0], lo[WIDTH-1:1]};
    end else begin
      n_hi = diff[WIDTH+1] ? shifted[WIDTH-1:0] : diff[WIDTH-1:0];
      n_lo = {lo[WIDTH-2:0], ~diff[WIDTH+1]};
    end
  end

  assign result = (mode_q == IT_REMU) ? n_hi : n_lo;
  assign hi_nz  = |n_hi;
  assign dz     = (m == '0);
  assign last   = busy && (cnt == '0);

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      busy   <= 1'b0;
      cnt    <= '0;
      hi     <= '0;
      lo     <= '0;
      m      <= '0;
      mode_q <= IT_MUL;
    end else if (start) begin
      busy   <= 1'b1;
      cnt    <= CW'(WIDTH - 1);
      hi     <= '0;
      lo     <= (mode == IT_MUL) ? b : a;
      m      <= (mode == IT_MUL) ? a : b;
      mode_q <= mode;
    end else if (busy) begin
      hi  <= n_hi;
      lo  <= n_lo;
      cnt <= cnt - 1'b1;
      if (cnt == '0) busy <= 1'b0;
    end
  end

endmodule

// File: rtl/alu_mc.sv
// Multi-cycle ALU with integrated register file: single-cycle ops complete at
// the accept edge, MUL/DIVU/REMU run WIDTH cycles in alu_iter.
module alu_mc import alu_pkg::*; #(
  parameter int WIDTH = 16,
  parameter int NREGS = 8,
  parameter int IW    = $clog2(NREGS),
  parameter int SW    = $clog2(WIDTH)
) (
  input logic     CLK,
  input logic     RST_N,
  alu_mc_if.slave bus
);

  logic [WIDTH-1:0]    regs [NREGS];
  state_e              state;
  logic [IW-1:0]       dst_q;
  logic                done_q;
  logic [STATUS_W-1:0] status_q;

  logic             accept, multi, start;
  logic [WIDTH-1:0] op1, op2;
  logic [SW-1:0]    shamt;
  iter_mode_e       it_mode;
  logic [WIDTH-1:0] it_result;
  logic             it_hi_nz, it_dz, it_last;

  logic [WIDTH:0]   wide;
  logic [WIDTH-1:0] sc_res;
  logic             sc_c, sc_wr, sc_cmp;

  logic             wr_en;
  logic [IW-1:0]    wr_idx;
  logic [WIDTH-1:0] wr_data;

  assign bus.op_ready  = (state == ST_IDLE);
  assign bus.dout      = regs[bus.src1_idx];
  assign bus.done      = done_q;
  assign bus.status    = status_q;
  assign bus.dbg_state = state;

  assign accept = bus.op_valid && bus.op_ready;
  assign multi  = is_multi(bus.op_code);
  assign start  = accept && multi;
  assign op1    = regs[bus.src1_idx];
  assign op2    = bus.use_imm ? bus.imm : regs[bus.src2_idx];
  assign shamt  = bus.shamt;

  always_comb begin
    it_mode = IT_MUL;
    case (bus.op_code)
      OP_DIVU: it_mode = IT_DIVU;
      OP_REMU: it_mode = IT_REMU;
      default: it_mode = IT_MUL;
    endcase
  end

  alu_iter #(.WIDTH(WIDTH)) u_iter (
    .CLK    (CLK),
    .RST_N  (RST_N),
    .start  (start),
    .mode   (it_mode),
    .a      (op1),
    .b      (op2),
    .result (it_result),
    .hi_nz  (it_hi_nz),
    .dz     (it_dz),
    .last   (it_last)
  );

  // Shifts run one bit wider so the last bit shifted out lands in the spare
  // bit; a zero shift leaves the spare bit clear, giving C=0.
  always_comb begin
    wide   = '0;
    sc_res = '0;
    sc_c   = 1'b0;
    sc_wr  = 1'b0;
    sc_cmp = 1'b0;
    case (bus.op_code)
      OP_ADD: begin
        wide = {1'b0, op1} + {1'b0, op2};
        sc_res = wide[WIDTH-1:0]; sc_c = wide[WIDTH]; sc_wr = 1'b1;
      end
      OP_SUB: begin
        wide = {1'b0, op1} - {1'b0, op2};
        sc_res = wide[WIDTH-1:0]; sc_c = wide[WIDTH]; sc_wr = 1'b1;
      end
      OP_AND:  begin sc_res = op1 & op2; sc_wr = 1'b1; end
      OP_OR:   begin sc_res = op1 | op2; sc_wr = 1'b1; end
      OP_XOR:  begin sc_res = op1 ^ op2; sc_wr = 1'b1; end
      OP_NOT:  begin sc_res = ~op2;      sc_wr = 1'b1; end
      OP_SHL: begin
        wide = {1'b0, op1} << shamt;
        sc_res = wide[WIDTH-1:0]; sc_c = wide[WIDTH]; sc_wr = 1'b1;
      end
      OP_SHR: begin
        wide = {op1, 1'b0} >> shamt;
        sc_res = wide[WIDTH:1]; sc_c = wide[0]; sc_wr = 1'b1;
      end
      OP_SAR: begin
        wide = $signed({op1, 1'b0}) >>> shamt;
        sc_res = wide[WIDTH:1]; sc_c = wide[0]; sc_wr = 1'b1;
      end
      OP_LOAD: begin sc_res = op2; sc_wr = 1'b1; end
      OP_CMP:  sc_cmp = 1'b1;
      default: sc_wr = 1'b0;
    endcase
  end

  always_comb begin
    wr_en   = 1'b0;
    wr_idx  = bus.dst_idx;
    wr_data = sc_res;
    if (accept && sc_wr) begin
      wr_en = 1'b1;
    end else if ((state != ST_IDLE) && it_last) begin
      wr_en   = 1'b1;
      wr_idx  = dst_q;
      wr_data = it_result;
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      for (int i = 0; i < NREGS; i++) regs[i] <= '0;
    end else if (wr_en) begin
      regs[wr_idx] <= wr_data;
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state    <= ST_IDLE;
      dst_q    <= '0;
      done_q   <= 1'b0;
      status_q <= '0;
    end else begin
      done_q <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (accept) begin
            dst_q <= bus.dst_idx;
            if (bus.op_code == OP_MUL) begin
              state <= ST_MUL_RUN;
            end else if (multi) begin
              state <= ST_DIV_RUN;
            end else begin
              done_q <= 1'b1;
              if (sc_wr) begin
                status_q[SB_Z] <= (sc_res == '0);
                status_q[SB_C] <= sc_c;
                status_q[SB_N] <= sc_res[WIDTH-1];
              end
              if (sc_cmp) begin
                status_q[SB_EQ] <= (op1 == op2);
                status_q[SB_GT] <= (op1 > op2);
                status_q[SB_LT] <= (op1 < op2);
              end
            end
          end
        end
        ST_MUL_RUN, ST_DIV_RUN: begin
          if (it_last) begin
            state          <= ST_IDLE;
            done_q         <= 1'b1;
            status_q[SB_Z] <= (it_result == '0);
            status_q[SB_N] <= it_result[WIDTH-1];
            status_q[SB_C] <= (state == ST_MUL_RUN) ? it_hi_nz : 1'b0;
            if (state == ST_DIV_RUN) status_q[SB_DZ] <= it_dz;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_mc.sv
// Directed bench for alu_mc: a 16-bit/8-register instance for the main
// scenarios and a 32-bit/16-register instance for the wide latency case.
module tb_alu_mc;
  import alu_pkg::*;

  logic CLK   = 1'b0;
  logic RST_N = 1'b0;
  int   n_cmp = 0;
  int   n_err = 0;

  alu_mc_if #(.WIDTH(16), .NREGS(8))  b16 ();
  alu_mc_if #(.WIDTH(32), .NREGS(16)) b32 ();

  alu_mc #(.WIDTH(16), .NREGS(8))  dut16 (.CLK(CLK), .RST_N(RST_N), .bus(b16));
  alu_mc #(.WIDTH(32), .NREGS(16)) dut32 (.CLK(CLK), .RST_N(RST_N), .bus(b32));

  // clock / reset
  always #5 CLK = ~CLK;

  initial begin
    #400000;
    $display("FAIL watchdog: got no end, expected finish before 400000");
    $fatal(1, "timeout");
  end

  // driver tasks
  task automatic issue16(input logic [3:0] op, input int s1, input int s2, input int d,
                         input int ui, input int im, input int sh);
    b16.op_code  = op;
    b16.src1_idx = 3'(s1);
    b16.src2_idx = 3'(s2);
    b16.dst_idx  = 3'(d);
    b16.use_imm  = 1'(ui);
    b16.imm      = 16'(im);
    b16.shamt    = 4'(sh);
    b16.op_valid = 1'b1;
    @(posedge CLK); #1;
    b16.op_valid = 1'b0;
  endtask

  task automatic issue32(input logic [3:0] op, input int s1, input int d, input logic [31:0] im);
    b32.op_code  = op;
    b32.src1_idx = 4'(s1);
    b32.src2_idx = 4'd0;
    b32.dst_idx  = 4'(d);
    b32.use_imm  = 1'b1;
    b32.imm      = im;
    b32.shamt    = 5'd0;
    b32.op_valid = 1'b1;
    @(posedge CLK); #1;
    b32.op_valid = 1'b0;
  endtask

  task automatic wait16(output int lat);
    lat = 0;
    while (b16.op_ready !== 1'b1 && lat < 200) begin
      lat++;
      @(posedge CLK); #1;
    end
  endtask

  task automatic wait32(output int lat);
    lat = 0;
    while (b32.op_ready !== 1'b1 && lat < 200) begin
      lat++;
      @(posedge CLK); #1;
    end
  endtask

  task automatic rd16(input int idx, output logic [15:0] v);
    b16.src1_idx = 3'(idx);
    @(negedge CLK);
    v = b16.dout;
  endtask

  task automatic rd32(input int idx, output logic [31:0] v);
    b32.src1_idx = 4'(idx);
    @(negedge CLK);
    v = b32.dout;
  endtask

  // scenarios
  task automatic test_reset();
    logic [15:0] v;
    RST_N = 1'b0;
    repeat (3) @(posedge CLK);
    @(negedge CLK);
    RST_N = 1'b1;
    for (int i = 0; i < 8; i++) begin
      rd16(i, v);
      n_cmp++; if (v !== 16'h0000) begin n_err++; $display("FAIL reset_reg%0d: got %h expected 0000", i, v); end
    end
    n_cmp++; if (b16.status !== 7'h00) begin n_err++; $display("FAIL reset_status: got %h expected 00", b16.status); end
    n_cmp++; if (b16.op_ready !== 1'b1) begin n_err++; $display("FAIL reset_ready: got %b expected 1", b16.op_ready); end
    n_cmp++; if (b16.done !== 1'b0) begin n_err++; $display("FAIL reset_done: got %b expected 0", b16.done); end
    n_cmp++; if (b16.dbg_state !== ST_IDLE) begin n_err++; $display("FAIL reset_state: got %0d expected IDLE", b16.dbg_state); end
    n_cmp++; if (b32.status !== 7'h00 || b32.op_ready !== 1'b1) begin n_err++; $display("FAIL reset_w32: got %h/%b expected 00/1", b32.status, b32.op_ready); end
  endtask

  task automatic test_load_add();
    logic [15:0] v;
    issue16(OP_LOAD, 0, 0, 1, 1, 'hFFFF, 0);
    n_cmp++; if (b16.done !== 1'b1) begin n_err++; $display("FAIL done_load1: got %b expected 1", b16.done); end
    issue16(OP_LOAD, 0, 0, 2, 1, 'h0001, 0);
    n_cmp++; if (b16.done !== 1'b1) begin n_err++; $display("FAIL done_load2: got %b expected 1", b16.done); end
    issue16(OP_ADD, 1, 2, 3, 0, 0, 0);
    n_cmp++; if (b16.done !== 1'b1) begin n_err++; $display("FAIL done_add: got %b expected 1", b16.done); end
    @(posedge CLK); #1;
    n_cmp++; if (b16.done !== 1'b0) begin n_err++; $display("FAIL done_idle: got %b expected 0", b16.done); end
    rd16(3, v);
    n_cmp++; if (v !== 16'h0000) begin n_err++; $display("FAIL add_r3: got %h expected 0000", v); end
    n_cmp++; if (b16.status !== 7'h03) begin n_err++; $display("FAIL add_status: got %h expected 03", b16.status); end
    rd16(1, v);
    n_cmp++; if (v !== 16'hFFFF) begin n_err++; $display("FAIL load_r1: got %h expected ffff", v); end
  endtask

  task automatic test_sub_cmp();
    logic [15:0] v;
    issue16(OP_SUB, 2, 1, 4, 0, 0, 0);
    rd16(4, v);
    n_cmp++; if (v !== 16'h0002) begin n_err++; $display("FAIL sub_r4: got %h expected 0002", v); end
    n_cmp++; if (b16.status !== 7'h02) begin n_err++; $display("FAIL sub_status: got %h expected 02", b16.status); end
    issue16(OP_CMP, 1, 2, 0, 0, 0, 0);
    n_cmp++; if (b16.status !== 7'h12 || b16.done !== 1'b1) begin n_err++; $display("FAIL cmp_gt: got %h/%b expected 12/1", b16.status, b16.done); end
    issue16(OP_CMP, 1, 0, 0, 1, 'hFFFF, 0);
    n_cmp++; if (b16.status !== 7'h0A) begin n_err++; $display("FAIL cmp_eq: got %h expected 0a", b16.status); end
    issue16(OP_CMP, 2, 0, 0, 1, 'h0005, 0);
    n_cmp++; if (b16.status !== 7'h22) begin n_err++; $display("FAIL cmp_lt: got %h expected 22", b16.status); end
  endtask

  task automatic test_shifts();
    logic [15:0] v;
    issue16(OP_LOAD, 0, 0, 5, 1, 'h8003, 0);
    issue16(OP_SAR, 5, 0, 6, 0, 0, 1);
    rd16(6, v);
    n_cmp++; if (v !== 16'hC001 || b16.status !== 7'h26) begin n_err++; $display("FAIL sar: got %h/%h expected c001/26", v, b16.status); end
    issue16(OP_SHR, 5, 0, 6, 0, 0, 1);
    rd16(6, v);
    n_cmp++; if (v !== 16'h4001 || b16.status !== 7'h22) begin n_err++; $display("FAIL shr: got %h/%h expected 4001/22", v, b16.status); end
    issue16(OP_SHL, 5, 0, 7, 0, 0, 0);
    rd16(7, v);
    n_cmp++; if (v !== 16'h8003 || b16.status !== 7'h24) begin n_err++; $display("FAIL shl0: got %h/%h expected 8003/24", v, b16.status); end
    issue16(OP_SHL, 5, 0, 7, 0, 0, 15);
    rd16(7, v);
    n_cmp++; if (v !== 16'h8000 || b16.status !== 7'h26) begin n_err++; $display("FAIL shl15: got %h/%h expected 8000/26", v, b16.status); end
  endtask

  task automatic test_logic();
    logic [15:0] v;
    issue16(OP_AND, 5, 0, 6, 1, 'h00F1, 0);
    rd16(6, v);
    n_cmp++; if (v !== 16'h0001 || b16.status !== 7'h20) begin n_err++; $display("FAIL and: got %h/%h expected 0001/20", v, b16.status); end
    issue16(OP_OR, 5, 0, 6, 1, 'h0F00, 0);
    rd16(6, v);
    n_cmp++; if (v !== 16'h8F03 || b16.status !== 7'h24) begin n_err++; $display("FAIL or: got %h/%h expected 8f03/24", v, b16.status); end
    issue16(OP_XOR, 1, 0, 6, 1, 'h00FF, 0);
    rd16(6, v);
    n_cmp++; if (v !== 16'hFF00 || b16.status !== 7'h24) begin n_err++; $display("FAIL xor: got %h/%h expected ff00/24", v, b16.status); end
    issue16(OP_NOT, 0, 0, 6, 1, 'hFFFF, 0);
    rd16(6, v);
    n_cmp++; if (v !== 16'h0000 || b16.status !== 7'h21) begin n_err++; $display("FAIL not: got %h/%h expected 0000/21", v, b16.status); end
    issue16(4'd15, 1, 0, 6, 1, 'h1234, 0);
    n_cmp++; if (b16.done !== 1'b1) begin n_err++; $display("FAIL unused_done: got %b expected 1", b16.done); end
    rd16(6, v);
    n_cmp++; if (v !== 16'h0000 || b16.status !== 7'h21) begin n_err++; $display("FAIL unused_nochg: got %h/%h expected 0000/21", v, b16.status); end
  endtask

  task automatic test_mul();
    logic [15:0] v;
    int lat;
    issue16(OP_LOAD, 0, 0, 1, 1, 'h0100, 0);
    issue16(OP_LOAD, 0, 0, 3, 1, 'h1234, 0);
    issue16(OP_MUL, 1, 0, 3, 1, 'h0100, 0);
    lat = 0;
    while (b16.op_ready !== 1'b1 && lat < 200) begin
      lat++;
      if (lat == 1) begin
        b16.op_code = OP_LOAD; b16.dst_idx = 3'd0; b16.imm = 16'hBEEF; b16.op_valid = 1'b1;
      end
      if (lat == 2) begin
        b16.src1_idx = 3'd3;
        #1;
        n_cmp++; if (b16.dout !== 16'h1234) begin n_err++; $display("FAIL mul_old_dst: got %h expected 1234", b16.dout); end
        n_cmp++; if (b16.dbg_state !== ST_MUL_RUN) begin n_err++; $display("FAIL mul_state: got %0d expected MUL_RUN", b16.dbg_state); end
      end
      if (lat == 4) b16.op_valid = 1'b0;
      @(posedge CLK); #1;
    end
    n_cmp++; if (lat !== 16) begin n_err++; $display("FAIL mul_latency: got %0d expected 16", lat); end
    n_cmp++; if (b16.done !== 1'b1) begin n_err++; $display("FAIL mul_done: got %b expected 1", b16.done); end
    n_cmp++; if (b16.status !== 7'h23) begin n_err++; $display("FAIL mul_status: got %h expected 23", b16.status); end
    issue16(OP_LOAD, 0, 0, 2, 1, 'h0042, 0);
    n_cmp++; if (b16.done !== 1'b1) begin n_err++; $display("FAIL b2b_done: got %b expected 1", b16.done); end
    rd16(2, v);
    n_cmp++; if (v !== 16'h0042) begin n_err++; $display("FAIL b2b_r2: got %h expected 0042", v); end
    rd16(3, v);
    n_cmp++; if (v !== 16'h0000) begin n_err++; $display("FAIL mul_r3: got %h expected 0000", v); end
    rd16(0, v);
    n_cmp++; if (v !== 16'h0000) begin n_err++; $display("FAIL mul_blocked_r0: got %h expected 0000", v); end
    issue16(OP_LOAD, 0, 0, 1, 1, 'h00FF, 0);
    issue16(OP_MUL, 1, 0, 3, 1, 'h0101, 0);
    wait16(lat);
    rd16(3, v);
    n_cmp++; if (v !== 16'hFFFF || b16.status !== 7'h24) begin n_err++; $display("FAIL mul_nc: got %h/%h expected ffff/24", v, b16.status); end
  endtask

  task automatic test_reset_mid_mul();
    logic [15:0] v;
    issue16(OP_LOAD, 0, 0, 3, 1, 'h5555, 0);
    issue16(OP_MUL, 3, 0, 3, 1, 'h0003, 0);
    repeat (5) @(posedge CLK);
    #1;
    RST_N = 1'b0;
    #1;
    n_cmp++; if (b16.dbg_state !== ST_IDLE || b16.op_ready !== 1'b1) begin n_err++; $display("FAIL abort_state: got %0d/%b expected IDLE/1", b16.dbg_state, b16.op_ready); end
    @(negedge CLK);
    RST_N = 1'b1;
    repeat (20) @(posedge CLK);
    #1;
    n_cmp++; if (b16.done !== 1'b0) begin n_err++; $display("FAIL abort_done: got %b expected 0", b16.done); end
    rd16(3, v);
    n_cmp++; if (v !== 16'h0000) begin n_err++; $display("FAIL abort_r3: got %h expected 0000", v); end
  endtask

  task automatic test_div();
    logic [15:0] v;
    int lat;
    issue16(OP_LOAD, 0, 0, 1, 1, 100, 0);
    issue16(OP_DIVU, 1, 0, 2, 1, 7, 0);
    wait16(lat);
    n_cmp++; if (lat !== 16 || b16.done !== 1'b1) begin n_err++; $display("FAIL div_latency: got %0d/%b expected 16/1", lat, b16.done); end
    rd16(2, v);
    n_cmp++; if (v !== 16'd14 || b16.status !== 7'h00) begin n_err++; $display("FAIL divu_100_7: got %h/%h expected 000e/00", v, b16.status); end
    issue16(OP_REMU, 1, 0, 2, 1, 7, 0);
    wait16(lat);
    rd16(2, v);
    n_cmp++; if (v !== 16'd2) begin n_err++; $display("FAIL remu_100_7: got %h expected 0002", v); end
    issue16(OP_LOAD, 0, 0, 4, 1, 5, 0);
    issue16(OP_DIVU, 4, 0, 5, 1, 0, 0);
    wait16(lat);
    rd16(5, v);
    n_cmp++; if (v !== 16'hFFFF || b16.status !== 7'h44) begin n_err++; $display("FAIL divu_by0: got %h/%h expected ffff/44", v, b16.status); end
    issue16(OP_REMU, 4, 0, 6, 1, 0, 0);
    wait16(lat);
    rd16(6, v);
    n_cmp++; if (v !== 16'd5 || b16.status !== 7'h40) begin n_err++; $display("FAIL remu_by0: got %h/%h expected 0005/40", v, b16.status); end
    issue16(OP_LOAD, 0, 0, 4, 1, 9, 0);
    n_cmp++; if (b16.status !== 7'h40) begin n_err++; $display("FAIL dz_sticky: got %h expected 40", b16.status); end
    issue16(OP_DIVU, 4, 0, 5, 1, 3, 0);
    wait16(lat);
    rd16(5, v);
    n_cmp++; if (v !== 16'd3 || b16.status !== 7'h00) begin n_err++; $display("FAIL divu_9_3: got %h/%h expected 0003/00", v, b16.status); end
    issue16(OP_DIVU, 1, 4, 7, 0, 0, 0);
    wait16(lat);
    rd16(7, v);
    n_cmp++; if (v !== 16'd11) begin n_err++; $display("FAIL divu_reg: got %h expected 000b", v); end
    issue16(OP_REMU, 1, 4, 7, 0, 0, 0);
    wait16(lat);
    rd16(7, v);
    n_cmp++; if (v !== 16'd1) begin n_err++; $display("FAIL remu_reg: got %h expected 0001", v); end
  endtask

  task automatic test_wide();
    logic [31:0] v;
    int lat;
    issue32(OP_LOAD, 0, 15, 32'h0001_0000);
    issue32(OP_MUL, 15, 9, 32'h0001_0000);
    wait32(lat);
    n_cmp++; if (lat !== 32 || b32.done !== 1'b1) begin n_err++; $display("FAIL w32_mul_latency: got %0d/%b expected 32/1", lat, b32.done); end
    rd32(9, v);
    n_cmp++; if (v !== 32'h0 || b32.status !== 7'h03) begin n_err++; $display("FAIL w32_mul: got %h/%h expected 00000000/03", v, b32.status); end
    issue32(OP_DIVU, 15, 10, 32'd3);
    wait32(lat);
    n_cmp++; if (lat !== 32) begin n_err++; $display("FAIL w32_div_latency: got %0d expected 32", lat); end
    rd32(10, v);
    n_cmp++; if (v !== 32'h0000_5555 || b32.status !== 7'h00) begin n_err++; $display("FAIL w32_divu: got %h/%h expected 00005555/00", v, b32.status); end
    issue32(OP_REMU, 15, 11, 32'd3);
    wait32(lat);
    rd32(11, v);
    n_cmp++; if (v !== 32'd1) begin n_err++; $display("FAIL w32_remu: got %h expected 00000001", v); end
    rd32(15, v);
    n_cmp++; if (v !== 32'h0001_0000) begin n_err++; $display("FAIL w32_r15: got %h expected 00010000", v); end
  endtask

  // sequence and final report
  initial begin
    b16.op_valid = 1'b0; b16.op_code = 4'd0; b16.src1_idx = '0; b16.src2_idx = '0;
    b16.dst_idx = '0; b16.use_imm = 1'b0; b16.imm = '0; b16.shamt = '0;
    b32.op_valid = 1'b0; b32.op_code = 4'd0; b32.src1_idx = '0; b32.src2_idx = '0;
    b32.dst_idx = '0; b32.use_imm = 1'b0; b32.imm = '0; b32.shamt = '0;
    test_reset();
    test_load_add();
    test_sub_cmp();
    test_shifts();
    test_logic();
    test_mul();
    test_reset_mid_mul();
    test_div();
    test_wide();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
